// File: rtl/gerador_imediato_fila.sv
// Buffered RISC-V immediate generator: decodes at push time and queues results with a tag.
// Optional macro IMM_ZICSR_EN adds the CSR uimm format (Z = 0110).
module gerador_imediato_fila #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned AUTO_DECODE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic [3:0]             select_imm,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        imm,
  output logic [3:0]             fmt,
  output logic                   illegal,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [3:0] FmtR   = 4'b0000;
  localparam logic [3:0] FmtI   = 4'b0001;
  localparam logic [3:0] FmtS   = 4'b0010;
  localparam logic [3:0] FmtSb  = 4'b0011;
  localparam logic [3:0] FmtU   = 4'b0100;
  localparam logic [3:0] FmtUj  = 4'b0101;
  localparam logic [3:0] FmtZ   = 4'b0110;
  localparam logic [3:0] FmtBad = 4'b1111;

  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   imm_mem [DEPTH];
  logic [3:0]        fmt_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem [DEPTH];

  logic              push, pop;
  logic [3:0]        fmt_new;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_new;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Format resolution: opcode map or explicit select code.
  always_comb begin
    fmt_new = FmtBad;
    if (AUTO_DECODE != 0) begin
      case (instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: fmt_new = FmtI;
`ifdef IMM_ZICSR_EN
        7'b1110011: fmt_new = instr[14] ? FmtZ : FmtI;
`else
        7'b1110011: fmt_new = FmtI;
`endif
        7'b0100011:             fmt_new = FmtS;
        7'b1100011:             fmt_new = FmtSb;
        7'b0110111, 7'b0010111: fmt_new = FmtU;
        7'b1101111:             fmt_new = FmtUj;
        7'b0110011, 7'b0111011: fmt_new = FmtR;
        default:                fmt_new = FmtBad;
      endcase
    end else begin
      case (select_imm)
        FmtR, FmtI, FmtS, FmtSb, FmtU, FmtUj: fmt_new = select_imm;
`ifdef IMM_ZICSR_EN
        FmtZ:                                 fmt_new = FmtZ;
`endif
        default:                              fmt_new = FmtBad;
      endcase
    end
  end

  // Every format is built as a 32-bit value whose bit 31 is the correct extension bit.
  always_comb begin
    imm32 = '0;
    case (fmt_new)
      FmtI:  imm32 = {{20{instr[31]}}, instr[31:20]};
      FmtS:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FmtSb: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FmtU:  imm32 = {instr[31:12], 12'b0};
      FmtUj: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      FmtZ:  imm32 = {27'b0, instr[19:15]};
`endif
      default: imm32 = '0;
    endcase
    imm_new = XLEN'($signed(imm32));
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      imm_mem[tail_q] <= imm_new;
      fmt_mem[tail_q] <= fmt_new;
      tag_mem[tail_q] <= in_tag;
    end
  end

  always_comb begin
    imm     = '0;
    fmt     = '0;
    illegal = 1'b0;
    out_tag = '0;
    if (out_valid) begin
      imm     = imm_mem[head_q];
      fmt     = fmt_mem[head_q];
      illegal = (fmt_mem[head_q] == FmtBad);
      out_tag = tag_mem[head_q];
    end
  end

endmodule
